// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W_DEF    = 10;
  localparam int unsigned INSTR_W_DEF = 9;
  localparam int unsigned OFF_W_DEF   = 8;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/next_pc.sv
// Sequential/branch next-PC adder: pc + 1 + sext(offset) when taken, modulo 2^PC_W.
module next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned OFF_W = OFF_W_DEF
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] offset,
  input  logic             take_branch,
  output logic [PC_W-1:0]  pc_nxt_c
);

  logic [PC_W-1:0] w_sext;
  logic [PC_W-1:0] w_disp;

  assign w_sext   = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign w_disp   = take_branch ? w_sext : '0;
  assign pc_nxt_c = pc + PC_W'(1) + w_disp;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: start/halt sequencing, PC register, zero-latency fetch and retired-instruction counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned OFF_W   = OFF_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               run,
  input  logic               take_branch,
  input  logic [OFF_W-1:0]   offset,
  input  logic               done_i,
  output logic [PC_W-1:0]    pc,
  output logic               done_o,
  output logic [CNT_W-1:0]   instr_count
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [PC_W-1:0]  w_pc_seq;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  next_pc #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_next_pc (
    .pc          (r_pc),
    .offset      (offset),
    .take_branch (take_branch),
    .pc_nxt_c    (w_pc_seq)
  );

  // Counter sticks at all-ones instead of wrapping.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A restart request in RUN aborts the current instruction; it is neither counted nor advanced.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_pc_nxt  = start_pc;
        w_cnt_nxt = '0;
        if (!start) w_state_nxt = RUN;
      end
      RUN: begin
        if (start) begin
          w_state_nxt = LOAD;
        end else if (done_i) begin
          w_state_nxt = HALT;
          w_cnt_nxt   = w_cnt_inc;
        end else begin
          w_pc_nxt  = w_pc_seq;
          w_cnt_nxt = w_cnt_inc;
        end
      end
      HALT: begin
        if (start) w_state_nxt = LOAD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign run         = (r_state == RUN);
  assign done_o      = (r_state == HALT);
  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign instr       = run ? imem_data : INSTR_W'(NOP_INSTR);
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a cycle-level reference model and per-cycle output comparison.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] start_pc;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic [8:0] instr;
  logic       run;
  logic       take_branch;
  logic [7:0] offset;
  logic       done_i;
  logic [9:0] pc;
  logic       done_o;
  logic [15:0] instr_count;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: mode 0=idle 1=load 2=run 3=halt
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_pc    (start_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .run         (run),
    .take_branch (take_branch),
    .offset      (offset),
    .done_i      (done_i),
    .pc          (pc),
    .done_o      (done_o),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word = addr*7+3, truncated to 9 bits.
  always_comb imem_data = 9'((32'(imem_addr) * 7 + 3));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_pc   = 0;
      m_cnt  = 0;
    end else begin
      case (m_mode)
        0: if (start) m_mode = 1;
        1: begin
          m_pc  = int'(start_pc);
          m_cnt = 0;
          if (!start) m_mode = 2;
        end
        2: begin
          if (start) begin
            m_mode = 1;
          end else begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (done_i) m_mode = 3;
            else if (take_branch)
              m_pc = (((m_pc + 1 + int'($signed(offset))) % 1024) + 1024) % 1024;
            else
              m_pc = (m_pc + 1) % 1024;
          end
        end
        default: if (start) m_mode = 1;
      endcase
    end
  end

  always @(negedge clk) begin
    check("cyc_pc", int'(pc), m_pc);
    check("cyc_imem_addr", int'(imem_addr), m_pc);
    check("cyc_run", int'(run), int'(m_mode == 2));
    check("cyc_done_o", int'(done_o), int'(m_mode == 3));
    check("cyc_count", int'(instr_count), m_cnt);
    check("cyc_instr", int'(instr), (m_mode == 2) ? ((m_pc * 7 + 3) % 512) : 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_run(input logic [9:0] p);
    start_pc = p;
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start_pc = '0;
    take_branch = 1'b0;
    offset = '0;
    done_i = 1'b0;
    #12;
    check("rst_pc", int'(pc), 0);
    check("rst_run", int'(run), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_instr", int'(instr), 0);
    rst_n = 1'b1;
    cyc();

    // Sequential run from 0x010
    load_run(10'h010);
    check("seq_pc0", int'(pc), 'h010);
    check("seq_run", int'(run), 1);
    check("seq_instr0", int'(instr), 'h073);
    cyc();
    check("seq_pc1", int'(pc), 'h011);
    cyc();
    check("seq_pc2", int'(pc), 'h012);

    // Branches from 0x020
    load_run(10'h020);
    take_branch = 1'b1; offset = 8'hFC;
    cyc();
    check("br_neg4", int'(pc), 'h01D);
    take_branch = 1'b0;
    load_run(10'h020);
    take_branch = 1'b1; offset = 8'h03;
    cyc();
    check("br_pos3", int'(pc), 'h024);
    take_branch = 1'b0;
    load_run(10'h020);
    cyc();
    check("br_not_taken", int'(pc), 'h021);

    // Wrap at both ends
    load_run(10'h3FF);
    cyc();
    check("wrap_up", int'(pc), 'h000);
    load_run(10'h001);
    take_branch = 1'b1; offset = 8'hF8;
    cyc();
    check("wrap_down", int'(pc), 'h3FA);
    take_branch = 1'b0;

    // Halt after five instructions
    load_run(10'h040);
    repeat (5) cyc();
    check("halt_pre_pc", int'(pc), 'h045);
    check("halt_pre_cnt", int'(instr_count), 5);
    done_i = 1'b1;
    cyc();
    done_i = 1'b0;
    check("halt_done", int'(done_o), 1);
    check("halt_run", int'(run), 0);
    check("halt_pc", int'(pc), 'h045);
    check("halt_cnt", int'(instr_count), 6);
    take_branch = 1'b1; offset = 8'h10; done_i = 1'b1;
    repeat (3) cyc();
    check("halt_frozen_pc", int'(pc), 'h045);
    check("halt_frozen_cnt", int'(instr_count), 6);
    check("halt_frozen_done", int'(done_o), 1);
    take_branch = 1'b0; done_i = 1'b0;

    // Restart takes priority over halt and branch
    load_run(10'h050);
    cyc();
    cyc();
    check("prio_pre_pc", int'(pc), 'h052);
    start = 1'b1; done_i = 1'b1; take_branch = 1'b1; offset = 8'h05;
    cyc();
    check("prio_not_halt", int'(done_o), 0);
    check("prio_run", int'(run), 0);
    done_i = 1'b0; take_branch = 1'b0; start_pc = 10'h100;
    cyc();
    check("prio_cnt_clr", int'(instr_count), 0);
    start = 1'b0;
    cyc();
    check("prio_pc", int'(pc), 'h100);
    check("prio_instr", int'(instr), 'h103);
    check("prio_run2", int'(run), 1);

    // Asynchronous reset mid-run
    load_run(10'h003);
    cyc();
    cyc();
    check("arst_pre_pc", int'(pc), 'h005);
    check("arst_pre_cnt", int'(instr_count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc", int'(pc), 0);
    check("arst_run", int'(run), 0);
    check("arst_done", int'(done_o), 0);
    check("arst_cnt", int'(instr_count), 0);
    check("arst_instr", int'(instr), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_pc", int'(pc), 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
